// File: rtl/prefetch_queue.sv
// prefetch_queue: sequential byte prefetcher feeding decode through a DEPTH-entry queue, with jump flush/redirect
module prefetch_queue #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         jump,
    input  logic [ADDR_WIDTH-1:0]        jumpAddr,
    output logic [ADDR_WIDTH-1:0]        memAddr,
    output logic                         memStrobe,
    input  logic [7:0]                   memDataRead,
    output logic [7:0]                   instrByte,
    output logic [ADDR_WIDTH-1:0]        instrPc,
    output logic                         instrValid,
    input  logic                         instrReady,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = 8 + ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
    logic                  in_flight_q, in_flight_d;
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [LW-1:0]         level_q, level_d;
    logic [EW-1:0]         store_q [DEPTH];
    logic                  pop, push, strobe;
    logic [LW:0]           demand;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Issue a fetch whenever the queue plus the outstanding byte still leaves room; jump flushes everything
    always_comb begin
        pop         = (level_q != '0) & instrReady;
        push        = in_flight_q & ~jump;
        demand      = {1'b0, level_q} + (LW+1)'(in_flight_q) - (LW+1)'(pop);
        strobe      = rst_n & ~jump & (demand < (LW+1)'(DEPTH));
        fetch_pc_d  = jump ? jumpAddr : strobe ? fetch_pc_q + ADDR_WIDTH'(1) : fetch_pc_q;
        req_pc_d    = strobe ? fetch_pc_q : req_pc_q;
        in_flight_d = strobe;
        head_d      = jump ? '0 : pop ? ptr_next(head_q) : head_q;
        tail_d      = jump ? '0 : push ? ptr_next(tail_q) : tail_q;
        level_d     = jump ? '0 : level_q + LW'(push) - LW'(pop);
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= RESET_PC;
            in_flight_q <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            level_q     <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            in_flight_q <= in_flight_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            level_q     <= level_d;
        end
    end

    // Queue payload needs no reset: entries are only read while counted in level
    always_ff @(posedge clk) begin
        if (push) store_q[tail_q] <= {memDataRead, req_pc_q};
    end

    assign memAddr    = fetch_pc_q;
    assign memStrobe  = strobe;
    assign instrValid = level_q != '0;
    assign level      = level_q;
    assign {instrByte, instrPc} = instrValid ? store_q[head_q] : '0;
endmodule
